// File: rtl/mem_responder.sv
// Byte-serial memory responder: services one byte/half/word load or store per
// req/ack handshake as single-byte accesses to an 8-bit RAM port.
module mem_responder #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [7:0]        ram_q
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;
    localparam logic [1:0] CNT_LAST   = 2'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       ld_q, ld_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic              ram_rden_q, ram_rden_d;

    logic [1:0]        idx_inc;
    logic [1:0]        last_idx;
    logic              bad_req;
    logic [31:0]       ld_cap;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic u);
        logic [31:0] r;
        case (sz)
            2'd0:    r = u ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'd1:    r = u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        idx_inc  = idx_q + 2'd1;
        last_idx = (size_q == 2'd2) ? 2'd3 : (size_q == 2'd1) ? 2'd1 : 2'd0;
        bad_req  = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                   (size == 2'd2 && addr[1:0] != 2'b00);
        ld_cap   = ld_q;
        ld_cap[{idx_q, 3'b000} +: 8] = ram_q;

        state_d    = state_q;
        size_d     = size_q;
        uns_d      = uns_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ld_d       = ld_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        ram_rden_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Alignment/size check happens on the accepting edge itself.
                if (req) begin
                    size_d  = size;
                    uns_d   = uns;
                    base_d  = addr;
                    wdata_d = wdata;
                    idx_d   = 2'd0;
                    cnt_d   = 2'd0;
                    if (bad_req) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end else if (we) begin
                        state_d    = S_WR;
                        ram_wren_d = 1'b1;
                        ram_addr_d = addr;
                        ram_data_d = wdata[7:0];
                    end else begin
                        state_d    = S_RD_ISSUE;
                        ram_rden_d = 1'b1;
                        ram_addr_d = addr;
                    end
                end
            end
            S_WR: begin
                if (idx_q == last_idx) begin
                    state_d = S_RESP;
                end else begin
                    idx_d      = idx_inc;
                    ram_wren_d = 1'b1;
                    ram_addr_d = base_q + ADDR_W'(idx_inc);
                    ram_data_d = wdata_q[{idx_inc, 3'b000} +: 8];
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
                cnt_d   = 2'd0;
            end
            S_RD_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    ld_d = ld_cap;
                    if (idx_q == last_idx) begin
                        state_d = S_RESP;
                        rdata_d = extend(ld_cap, size_q, uns_q);
                    end else begin
                        state_d    = S_RD_ISSUE;
                        idx_d      = idx_inc;
                        ram_rden_d = 1'b1;
                        ram_addr_d = base_q + ADDR_W'(idx_inc);
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            base_q     <= '0;
            wdata_q    <= 32'h0;
            idx_q      <= 2'd0;
            cnt_q      <= 2'd0;
            ld_q       <= 32'h0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= 8'h0;
            ram_wren_q <= 1'b0;
            ram_rden_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            ld_q       <= ld_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            ram_rden_q <= ram_rden_d;
        end
    end

    // Enables are masked by rst so an aborted store writes nothing on the reset edge.
    assign ram_wren = ram_wren_q & ~rst;
    assign ram_rden = ram_rden_q & ~rst;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ack      = (state_q == S_RESP);
    assign err      = err_q;
    assign busy     = (state_q != S_IDLE);
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with a behavioural byte RAM of latency RD_LAT.
module tb_mem_responder;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'd0;
    logic        uns = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack, err, busy, ram_wren, ram_rden;
    logic [31:0] rdata;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data, ram_q;

    mem_responder #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
        .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    logic [7:0]  mem [0:65535];
    logic [7:0]  q_pipe [RD_LAT];

    assign ram_q = q_pipe[RD_LAT-1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
        q_pipe[0] <= ram_rden ? mem[ram_addr] : 8'h5A;
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end

    typedef struct {
        string       tag;
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] last_ack_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: pops the oldest expectation on every ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ram_wren) wr_pulses++;
            if (ram_rden) rd_pulses++;
            if (ack) begin
                if (sb.size() == 0) begin
                    chk("spurious_ack", {31'h0, ack}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_cyc"}, cyc, e.cyc);
                    chk({e.tag, "_err"}, {31'h0, err}, {31'h0, e.err});
                    chk({e.tag, "_rdata"}, rdata, e.rdata);
                    $display("txn %s ack at cyc=%0d err=%0b rdata=%h", e.tag, cyc, err, rdata);
                end
                last_ack_rdata = rdata;
            end
        end
    end

    // Reference model for one request, evaluated in the negedge before the sampling edge.
    task automatic push_exp(input string tag, input logic w, input logic [1:0] sz,
                            input logic u, input logic [15:0] a);
        exp_t        e;
        int          n;
        int          lat;
        logic        bad;
        logic [31:0] v;
        logic [15:0] ai;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        if (bad)    lat = 1;
        else if (w) lat = n + 1;
        else        lat = 1 + n * (RD_LAT + 1);
        if (!bad && !w) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) begin
                ai = a + 16'(i);
                v[8*i +: 8] = mem[ai];
            end
            if (n == 1)      v = u ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            else if (n == 2) v = u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            last_rdata = v;
        end
        e.tag   = tag;
        e.cyc   = cyc + lat;
        e.err   = bad;
        e.rdata = last_rdata;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            chk("idle_timeout_busy", {31'h0, busy}, 32'h0);
            chk("idle_timeout_sb", sb.size(), 32'h0);
            sb.delete();
        end
    endtask

    task automatic wait_ack(input string tag);
        int t = 0;
        @(negedge clk);
        while (!ack && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk({tag, "_ack_timeout"}, {31'h0, ack}, 32'h1);
    endtask

    task automatic issue(input string tag, input logic w, input logic [1:0] sz,
                         input logic u, input logic [15:0] a, input logic [31:0] wd,
                         input bit push, input bit hold);
        we = w; size = sz; uns = u; addr = a; wdata = wd; req = 1'b1;
        if (push) push_exp(tag, w, sz, u, a);
        @(negedge clk);
        if (!hold) req = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [15:0] a, input logic [31:0] wd);
        wait_idle();
        issue(tag, w, sz, u, a, wd, 1'b1, 1'b0);
        wait_idle();
    endtask

    initial begin
        int wr0, rd0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_wren", {31'h0, ram_wren}, 32'h0);
        chk("rst_rden", {31'h0, ram_rden}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr", {16'h0, ram_addr}, 32'h0);
        chk("rst_data", {24'h0, ram_data}, 32'h0);
        rst = 1'b0;

        do_req("st_word", 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        chk("mem10", {24'h0, mem[16'h0010]}, 32'hEF);
        chk("mem11", {24'h0, mem[16'h0011]}, 32'hBE);
        chk("mem12", {24'h0, mem[16'h0012]}, 32'hAD);
        chk("mem13", {24'h0, mem[16'h0013]}, 32'hDE);
        rd0 = rd_pulses;
        do_req("ld_word", 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        chk("ld_word_val", last_ack_rdata, 32'hDEADBEEF);
        chk("ld_word_rden", rd_pulses - rd0, 32'd4);

        do_req("st_half", 1'b1, 2'd1, 1'b0, 16'h0020, 32'h12348001);
        do_req("ld_byte_s", 1'b0, 2'd0, 1'b0, 16'h0021, 32'h0);
        chk("ld_byte_s_val", last_ack_rdata, 32'hFFFFFF80);
        do_req("ld_byte_u", 1'b0, 2'd0, 1'b1, 16'h0021, 32'h0);
        chk("ld_byte_u_val", last_ack_rdata, 32'h00000080);
        do_req("ld_half_s", 1'b0, 2'd1, 1'b0, 16'h0020, 32'h0);
        chk("ld_half_s_val", last_ack_rdata, 32'hFFFF8001);

        wr0 = wr_pulses; rd0 = rd_pulses;
        do_req("err_half", 1'b0, 2'd1, 1'b0, 16'h0011, 32'h0);
        do_req("err_word", 1'b1, 2'd2, 1'b0, 16'h0012, 32'h55667788);
        do_req("err_size3", 1'b0, 2'd3, 1'b0, 16'h0000, 32'h0);
        chk("err_no_wren", wr_pulses - wr0, 32'd0);
        chk("err_no_rden", rd_pulses - rd0, 32'd0);
        chk("err_mem12", {24'h0, mem[16'h0012]}, 32'hAD);

        // Reset lands in the third write cycle of a word store.
        wait_idle();
        issue("st_abort", 1'b1, 2'd2, 1'b0, 16'h0040, 32'h11223344, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_rdata = 32'h0;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_ack", {31'h0, ack}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_mem40", {24'h0, mem[16'h0040]}, 32'h44);
        chk("abort_mem41", {24'h0, mem[16'h0041]}, 32'h33);
        chk("abort_mem42", {24'h0, mem[16'h0042]}, 32'h00);
        chk("abort_mem43", {24'h0, mem[16'h0043]}, 32'h00);
        do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 16'h0040, 32'h0);
        chk("ld_after_rst_val", last_ack_rdata, 32'h00003344);

        // req held high across two back-to-back byte loads.
        wait_idle();
        issue("held1", 1'b0, 2'd0, 1'b1, 16'h0021, 32'h0, 1'b1, 1'b1);
        wait_ack("held1");
        chk("held1_val", last_ack_rdata, 32'h00000080);
        addr = 16'h0020;
        @(negedge clk);
        push_exp("held2", 1'b0, 2'd0, 1'b1, 16'h0020);
        wait_ack("held2");
        req = 1'b0;
        chk("held2_val", last_ack_rdata, 32'h00000001);
        wait_idle();

        do_req("st_top", 1'b1, 2'd2, 1'b0, 16'hFFFC, 32'hCAFEF00D);
        chk("memFFFC", {24'h0, mem[16'hFFFC]}, 32'h0D);
        chk("memFFFD", {24'h0, mem[16'hFFFD]}, 32'hF0);
        chk("memFFFE", {24'h0, mem[16'hFFFE]}, 32'hFE);
        chk("memFFFF", {24'h0, mem[16'hFFFF]}, 32'hCA);
        chk("mem0000", {24'h0, mem[16'h0000]}, 32'h00);
        do_req("ld_top", 1'b0, 2'd2, 1'b0, 16'hFFFC, 32'h0);
        chk("ld_top_val", last_ack_rdata, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
